// File: rtl/dpsk_bit_source.sv
// dpsk_bit_source: byte-to-serial symbol source for the DPSK modulator.
// Bytes arrive over a valid/ready handshake into a one-entry holding
// register, are shifted out MSB first at one bit per CLK_DIV clocks, and an
// idle bit is emitted whenever no data is being shifted. All symbol-side
// state changes only on baud ticks, so ser_code_out is a clean baud stream.
//
// Build option: define PN_IDLE_EN to make the idle bit the MSB of a 7-bit
// x^7+x^6+1 LFSR (seeded with PN_SEED). Without it the idle bit is a
// constant 0 (continuous carrier at the modulator) and no LFSR is built.

module dpsk_bit_source #(
    parameter int unsigned CLK_DIV = 50,
    parameter logic [6:0]  PN_SEED = 7'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       ser_code_out,
    output logic       sym_strobe,
    output logic       busy,
    output logic       frame_end
);

    localparam int unsigned CntW   = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    // Elaboration-time sanity checks on the configuration.
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("dpsk_bit_source: CLK_DIV must be >= 2");
    end
    if (PN_SEED == 7'h00) begin : g_bad_seed
        $error("dpsk_bit_source: PN_SEED must be non-zero");
    end

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            tick;

    // Holding register and handshake.
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic            byte_ready_q;
    logic            transfer;
    logic            load;

    // Shifter holds the bits still to be sent after the one on the line.
    logic [6:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;

    logic            ser_q, ser_d;
    logic            strobe_q;
    logic            frame_end_q, frame_end_d;
    logic            idle_bit;

    assign tick     = (cnt_q == CntMax);
    assign transfer = byte_valid & byte_ready_q;

    // Free-running baud counter, wraps at CLK_DIV-1 in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

`ifdef PN_IDLE_EN
    logic [6:0] lfsr_q, lfsr_d;

    assign idle_bit = lfsr_q[6];

    // LFSR advances once per idle-state tick and freezes while shifting data.
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick && (state_q == StIdle)) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= PN_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign idle_bit = 1'b0;
`endif

    // Symbol FSM: decides what goes on the line at each tick.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ser_d       = ser_q;
        frame_end_d = 1'b0;
        load        = 1'b0;

        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (hold_full_q) begin
                        load      = 1'b1;
                        shift_d   = hold_q[6:0];
                        ser_d     = hold_q[7];
                        bit_cnt_d = 3'd7;
                        state_d   = StShift;
                    end else begin
                        ser_d = idle_bit;
                    end
                end
                StShift: begin
                    if (bit_cnt_q != 3'd0) begin
                        ser_d     = shift_q[6];
                        shift_d   = {shift_q[5:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else if (hold_full_q) begin
                        // Back-to-back byte: reload without an idle gap.
                        load      = 1'b1;
                        shift_d   = hold_q[6:0];
                        ser_d     = hold_q[7];
                        bit_cnt_d = 3'd7;
                    end else begin
                        ser_d       = idle_bit;
                        frame_end_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Holding register next state. A transfer only happens while the hold is
    // empty and a load only while it is full, so the two never coincide.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (transfer) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
        end
    end

    // Symbol-side and handshake state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            ser_q        <= 1'b0;
            strobe_q     <= 1'b0;
            frame_end_q  <= 1'b0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            ser_q        <= ser_d;
            strobe_q     <= tick;
            frame_end_q  <= frame_end_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            // Tracks the next hold state so a second transfer cannot follow
            // the first one before the hold is unloaded.
            byte_ready_q <= !hold_full_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign ser_code_out = ser_q;
    assign sym_strobe   = strobe_q;
    assign busy         = (state_q == StShift);
    assign frame_end    = frame_end_q;

endmodule

// File: tb/tb_dpsk_bit_source.sv
// Directed testbench for dpsk_bit_source with CLK_DIV=4, PN_SEED=7'h7F.
module tb_dpsk_bit_source;

    localparam int unsigned ClkDiv = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       ser_code_out;
    logic       sym_strobe;
    logic       busy;
    logic       frame_end;

    int checks = 0;
    int failures = 0;

    dpsk_bit_source #(
        .CLK_DIV(ClkDiv),
        .PN_SEED(7'h7F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .ser_code_out(ser_code_out),
        .sym_strobe  (sym_strobe),
        .busy        (busy),
        .frame_end   (frame_end)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until sym_strobe is seen, bounded to a little over two symbols.
    task automatic wait_strobe(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 2 * ClkDiv + 2) begin
            step();
            n++;
            if (sym_strobe) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] pat;
        rst        = 1'b1;
        byte_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ser_code_out, sym_strobe, busy, frame_end, byte_ready} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got=%b want=00000", i,
                         {ser_code_out, sym_strobe, busy, frame_end, byte_ready});
            end
        end
        rst = 1'b0;
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                checks++;
                if (byte_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_byte_ready got=%b want=1", byte_ready);
                end
            end
            pat = {pat[6:0], sym_strobe};
        end
        checks++;
        if (pat !== 8'b0001_0001) begin
            failures++;
            $display("FAIL reset_tick_phase got=%b want=00010001", pat);
        end
    endtask

    task automatic test_single_byte();
        bit         ok;
        int         n;
        int         busy_cnt;
        int         fe_cnt;
        bit         br_bad;
        bit         fe_at9;
        logic       ninth;
        logic [7:0] bits;
        wait_strobe(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_align no strobe seen");
        end
        step();
        checks++;
        if (byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready_idle got=%b want=1", byte_ready);
        end
        byte_data  = 8'hA5;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        n = 0; busy_cnt = 0; fe_cnt = 0; br_bad = 0; fe_at9 = 0; ninth = 1'bx; bits = '0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (busy) busy_cnt++;
            if (frame_end) fe_cnt++;
            if (sym_strobe) begin
                n++;
                if (n <= 8) bits = {bits[6:0], ser_code_out};
                if (n == 9) begin
                    ninth  = ser_code_out;
                    fe_at9 = frame_end;
                end
            end else if (n == 0 && byte_ready) begin
                br_bad = 1'b1;
            end
        end
        checks++;
        if (bits !== 8'hA5) begin
            failures++;
            $display("FAIL single_bits got=%h want=a5", bits);
        end
        checks++;
        if (busy_cnt != 32) begin
            failures++;
            $display("FAIL single_busy_len got=%0d want=32", busy_cnt);
        end
        checks++;
        if (fe_cnt != 1 || !fe_at9) begin
            failures++;
            $display("FAIL single_frame_end count=%0d at_ninth=%0d want=1,1", fe_cnt, fe_at9);
        end
        checks++;
        if (br_bad) begin
            failures++;
            $display("FAIL single_ready_held got=1 before load want=0");
        end
`ifndef PN_IDLE_EN
        checks++;
        if (ninth !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_after got=%b want=0", ninth);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit          ok;
        bit          sent2;
        bit          fe_early;
        int          n;
        int          busy_cnt;
        int          fe_cnt;
        logic [15:0] bits;
        wait_strobe(ok);
        step();
        byte_data  = 8'hF0;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        n = 0; busy_cnt = 0; fe_cnt = 0; sent2 = 0; fe_early = 0; bits = '0;
        for (int i = 0; i < 80; i++) begin
            step();
            byte_valid = 1'b0;
            if (busy) busy_cnt++;
            if (sym_strobe) begin
                n++;
                if (n <= 16) bits = {bits[14:0], ser_code_out};
            end
            if (frame_end) begin
                fe_cnt++;
                if (n < 17) fe_early = 1'b1;
            end
            if (!sent2 && n >= 1 && byte_ready) begin
                byte_data  = 8'h0F;
                byte_valid = 1'b1;
                sent2      = 1'b1;
            end
        end
        checks++;
        if (bits !== 16'hF00F) begin
            failures++;
            $display("FAIL b2b_bits got=%h want=f00f", bits);
        end
        checks++;
        if (busy_cnt != 64) begin
            failures++;
            $display("FAIL b2b_busy_len got=%0d want=64", busy_cnt);
        end
        checks++;
        if (fe_cnt != 1 || fe_early || !sent2) begin
            failures++;
            $display("FAIL b2b_frame_end count=%0d early=%0d sent2=%0d want=1,0,1",
                     fe_cnt, fe_early, sent2);
        end
    endtask

    task automatic test_tick_transfer();
        bit         ok;
        bit         seen_fe;
        logic [3:0] pat;
        wait_strobe(ok);
        repeat (3) step();
        checks++;
        if (byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL tick_ready got=%b want=1", byte_ready);
        end
        byte_data  = 8'h80;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        checks++;
        if (sym_strobe !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tick_same_edge strobe=%b busy=%b want=1,0", sym_strobe, busy);
        end
`ifndef PN_IDLE_EN
        checks++;
        if (ser_code_out !== 1'b0) begin
            failures++;
            $display("FAIL tick_idle_bit got=%b want=0", ser_code_out);
        end
`endif
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            pat = {pat[2:0], sym_strobe};
        end
        checks++;
        if (pat !== 4'b0001 || busy !== 1'b1 || ser_code_out !== 1'b1) begin
            failures++;
            $display("FAIL tick_bit7 strobes=%b busy=%b ser=%b want=0001,1,1",
                     pat, busy, ser_code_out);
        end
        seen_fe = 1'b0;
        for (int i = 0; i < 40 && !seen_fe; i++) begin
            step();
            if (frame_end) seen_fe = 1'b1;
        end
        checks++;
        if (!seen_fe) begin
            failures++;
            $display("FAIL tick_drain frame_end not seen within 40 cycles");
        end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        bit         busy_seen;
        int         n;
        logic [2:0] first;
        logic [9:0] after;
        logic [9:0] want;
        wait_strobe(ok);
        step();
        byte_data  = 8'hFF;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        first = '0;
        for (int i = 0; i < 3; i++) begin
            wait_strobe(ok);
            first = {first[1:0], ser_code_out & ok};
        end
        checks++;
        if (first !== 3'b111) begin
            failures++;
            $display("FAIL mid_first_bits got=%b want=111", first);
        end
        // Queue a second byte in the hold so reset must discard it too.
        byte_data  = 8'hAA;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_code_out, sym_strobe, busy, frame_end, byte_ready} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b want=00000",
                     {ser_code_out, sym_strobe, busy, frame_end, byte_ready});
        end
        step();
        step();
        rst = 1'b0;
        n = 0; busy_seen = 0; after = '0;
        for (int i = 0; i < 60 && n < 10; i++) begin
            step();
            if (busy) busy_seen = 1'b1;
            if (sym_strobe) begin
                n++;
                after = {after[8:0], ser_code_out};
            end
        end
`ifdef PN_IDLE_EN
        want = 10'b1111111000;
`else
        want = 10'b0;
`endif
        checks++;
        if (after !== want || n != 10 || busy_seen) begin
            failures++;
            $display("FAIL mid_after_reset bits=%b n=%0d busy=%0d want=%b,10,0",
                     after, n, busy_seen, want);
        end
    endtask

    task automatic test_idle_pn();
        bit   pn [254];
        int   n;
        int   ones;
        bit   busy_seen;
        do_reset();
        n = 0; ones = 0; busy_seen = 0;
        for (int i = 0; i < 254 * ClkDiv + 10 && n < 254; i++) begin
            step();
            if (busy) busy_seen = 1'b1;
            if (sym_strobe) begin
                pn[n] = ser_code_out;
                if (ser_code_out) ones++;
                n++;
            end
        end
        checks++;
        if (n != 254 || busy_seen) begin
            failures++;
            $display("FAIL idle_count got=%0d busy=%0d want=254,0", n, busy_seen);
        end
`ifdef PN_IDLE_EN
        begin
            logic [7:0] head;
            int         mism;
            head = {pn[0], pn[1], pn[2], pn[3], pn[4], pn[5], pn[6], pn[7]};
            mism = 0;
            for (int i = 0; i < 127; i++) if (pn[i] != pn[i + 127]) mism++;
            checks++;
            if (head !== 8'hFE) begin
                failures++;
                $display("FAIL idle_pn_head got=%b want=11111110", head);
            end
            checks++;
            if (mism != 0 || ones != 128) begin
                failures++;
                $display("FAIL idle_pn_period mismatches=%0d ones=%0d want=0,128", mism, ones);
            end
        end
`else
        checks++;
        if (ones != 0) begin
            failures++;
            $display("FAIL idle_const ones=%0d want=0", ones);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_tick_transfer();
        test_reset_mid();
        test_idle_pn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
